// File: rtl/stream_downsizer.sv
// Wide-to-narrow stream converter: pops one word from a non-fall-through FIFO
// and replays it as RATIO narrow beats on a valid/ready stream.
module stream_downsizer #(
    parameter int unsigned  IN_WIDTH  = 32,
    parameter int unsigned  OUT_WIDTH = 8,
    parameter logic         LSB_FIRST = 1'b1,
    localparam int unsigned RATIO     = IN_WIDTH / OUT_WIDTH,
    localparam int unsigned CNT_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 flush_i,
    input  logic                 fifo_empty_i,
    input  logic [IN_WIDTH-1:0]  fifo_data_i,
    output logic                 fifo_pop_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [OUT_WIDTH-1:0] data_o,
    output logic                 last_o,
    output logic                 busy_o
);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(RATIO - 1);

    if ((IN_WIDTH % OUT_WIDTH) != 0 || RATIO < 1) begin : g_bad_width
        $error("stream_downsizer: IN_WIDTH must be a non-zero multiple of OUT_WIDTH");
    end

    state_e                               state_q, state_d;
    logic   [IN_WIDTH-1:0]                hold_q, hold_d;
    logic   [CNT_WIDTH-1:0]               cnt_q, cnt_d;
    logic   [RATIO-1:0][OUT_WIDTH-1:0]    slices;
    logic   [CNT_WIDTH-1:0]               beat_idx;
    logic                                 handshake;
    logic                                 is_last;

    assign slices    = hold_q;
    assign beat_idx  = LSB_FIRST ? cnt_q : (LAST_CNT - cnt_q);
    assign is_last   = (cnt_q == LAST_CNT);
    assign handshake = (state_q == SEND) & ready_i;

    assign valid_o = (state_q == SEND);
    assign busy_o  = (state_q == SEND);
    assign last_o  = (state_q == SEND) & is_last;
    assign data_o  = (state_q == SEND) ? slices[beat_idx] : '0;

    // Popping is gated by reset so a word is never taken from the FIFO only to be discarded.
    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        cnt_d      = cnt_q;
        fifo_pop_o = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty_i) begin
                    fifo_pop_o = 1'b1;
                    hold_d     = fifo_data_i;
                    cnt_d      = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (!is_last) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end else if (!fifo_empty_i) begin
                        fifo_pop_o = 1'b1;
                        hold_d     = fifo_data_i;
                        cnt_d      = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (flush_i) begin
            fifo_pop_o = 1'b0;
            hold_d     = hold_q;
            cnt_d      = '0;
            state_d    = IDLE;
        end

        if (!rst_ni) begin
            fifo_pop_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
